// File: rtl/parser_arb_pkg.sv
// Shared types and sizing helpers for the parser feed arbiter.
// Imported by the top level and the round-robin picker.
package parser_arb_pkg;

  localparam int unsigned CntWidth = 16;

  typedef enum logic [1:0] {
    StIdle,
    StLen,
    StBody,
    StWaitDone
  } arb_state_e;

  // Timer must be able to hold the value TIMEOUT_CYCLES itself.
  function automatic int unsigned timer_width(input int unsigned cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after last_ptr_i,
// wrapping cyclically; returns both one-hot and encoded forms.
module rr_arbiter
  import parser_arb_pkg::*;
#(
  parameter int unsigned NumReq = 4
) (
  input  logic [NumReq-1:0]            req_i,
  input  logic [idx_width(NumReq)-1:0] last_ptr_i,
  output logic [NumReq-1:0]            gnt_o,
  output logic [idx_width(NumReq)-1:0] idx_o
);

  localparam int unsigned IdxW = idx_width(NumReq);

  logic            found;
  logic [IdxW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned off = 1; off <= NumReq; off++) begin
      cand = IdxW'((32'(last_ptr_i) + off) % NumReq);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/parser_feed_arbiter.sv
// Grants the shared market_parser to one feed per length-prefixed message,
// round-robin, holding the grant until parser done or an idle timeout.
module parser_feed_arbiter
  import parser_arb_pkg::*;
#(
  parameter int unsigned NUM_FEEDS      = 4,
  parameter int unsigned DATA_WIDTH     = 7,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                                clk_in,
  input  logic                                reset_n_in,
  input  logic [NUM_FEEDS*(DATA_WIDTH+1)-1:0] feed_data_in,
  input  logic [NUM_FEEDS-1:0]                feed_valid_in,
  output logic [NUM_FEEDS-1:0]                feed_ready_out,
  output logic [DATA_WIDTH:0]                 parser_data_out,
  output logic                                parser_valid_out,
  output logic                                parser_start_out,
  output logic                                parser_flush_out,
  input  logic                                parser_done_in,
  output logic [NUM_FEEDS-1:0]                grant_out,
  output logic [CntWidth-1:0]                 msg_count_out,
  output logic [CntWidth-1:0]                 err_count_out
);

  localparam int unsigned ByteW  = DATA_WIDTH + 1;
  localparam int unsigned IdxW   = idx_width(NUM_FEEDS);
  localparam int unsigned TimerW = timer_width(TIMEOUT_CYCLES);
  // Compared before incrementing, so the abort lands after exactly TIMEOUT_CYCLES idle cycles.
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);

  arb_state_e            state_q;
  logic [NUM_FEEDS-1:0]  grant_q;
  logic [IdxW-1:0]       gidx_q;
  logic [IdxW-1:0]       last_ptr_q;
  logic [ByteW-1:0]      remaining_q;
  logic [TimerW-1:0]     timer_q;
  logic [ByteW-1:0]      data_q;
  logic                  valid_q;
  logic                  start_q;
  logic                  flush_q;
  logic [CntWidth-1:0]   msg_q;
  logic [CntWidth-1:0]   err_q;

  logic [NUM_FEEDS-1:0]  arb_gnt;
  logic [IdxW-1:0]       arb_idx;
  logic [ByteW-1:0]      feed_bytes [NUM_FEEDS];
  logic [ByteW-1:0]      cur_byte;
  logic                  cur_valid;
  logic                  timer_hit;

  for (genvar gi = 0; gi < NUM_FEEDS; gi++) begin : g_unpack
    assign feed_bytes[gi] = feed_data_in[gi*ByteW +: ByteW];
  end

  rr_arbiter #(
    .NumReq (NUM_FEEDS)
  ) u_rr_arbiter (
    .req_i      (feed_valid_in),
    .last_ptr_i (last_ptr_q),
    .gnt_o      (arb_gnt),
    .idx_o      (arb_idx)
  );

  assign cur_byte  = feed_bytes[gidx_q];
  assign cur_valid = feed_valid_in[gidx_q];
  assign timer_hit = (timer_q == TimerLast);

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      gidx_q      <= '0;
      last_ptr_q  <= IdxW'(NUM_FEEDS - 1);
      remaining_q <= '0;
      timer_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      start_q     <= 1'b0;
      flush_q     <= 1'b0;
      msg_q       <= '0;
      err_q       <= '0;
    end else begin
      valid_q <= 1'b0;
      start_q <= 1'b0;
      flush_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (|feed_valid_in) begin
            grant_q <= arb_gnt;
            gidx_q  <= arb_idx;
            state_q <= StLen;
          end
        end
        StLen: begin
          if (cur_valid) begin
            if (cur_byte == '0) begin
              err_q      <= err_q + CntWidth'(1);
              last_ptr_q <= gidx_q;
              grant_q    <= '0;
              state_q    <= StIdle;
            end else begin
              remaining_q <= cur_byte;
              data_q      <= cur_byte;
              valid_q     <= 1'b1;
              start_q     <= 1'b1;
              timer_q     <= '0;
              state_q     <= StBody;
            end
          end
        end
        StBody: begin
          if (cur_valid) begin
            data_q      <= cur_byte;
            valid_q     <= 1'b1;
            remaining_q <= remaining_q - ByteW'(1);
            timer_q     <= '0;
            if (remaining_q == ByteW'(1)) begin
              state_q <= StWaitDone;
            end
          end else if (timer_hit) begin
            flush_q    <= 1'b1;
            err_q      <= err_q + CntWidth'(1);
            last_ptr_q <= gidx_q;
            grant_q    <= '0;
            timer_q    <= '0;
            state_q    <= StIdle;
          end else begin
            timer_q <= timer_q + TimerW'(1);
          end
        end
        StWaitDone: begin
          // Done takes priority over a timeout landing in the same cycle.
          if (parser_done_in) begin
            msg_q      <= msg_q + CntWidth'(1);
            last_ptr_q <= gidx_q;
            grant_q    <= '0;
            timer_q    <= '0;
            state_q    <= StIdle;
          end else if (timer_hit) begin
            flush_q    <= 1'b1;
            err_q      <= err_q + CntWidth'(1);
            last_ptr_q <= gidx_q;
            grant_q    <= '0;
            timer_q    <= '0;
            state_q    <= StIdle;
          end else begin
            timer_q <= timer_q + TimerW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign feed_ready_out   = (state_q == StLen || state_q == StBody) ? grant_q : '0;
  assign grant_out        = grant_q;
  assign parser_data_out  = data_q;
  assign parser_valid_out = valid_q;
  assign parser_start_out = start_q;
  assign parser_flush_out = flush_q;
  assign msg_count_out    = msg_q;
  assign err_count_out    = err_q;

endmodule

// File: tb/tb_parser_feed_arbiter.sv
// Directed bench for parser_feed_arbiter: a table of single-feed messages plus
// hand sequences for round-robin, timeout and mid-message reset.
module tb_parser_feed_arbiter;

  localparam int unsigned NF = 4;
  localparam int unsigned DW = 7;
  localparam int unsigned TO = 8;

  typedef logic [1:0] fidx_t;

  typedef struct {
    fidx_t       feed;
    logic [7:0]  len;
    int          dly;    // done in this WAIT_DONE cycle (1-based); 0 = never
    logic [3:0]  gnt;
    logic [15:0] msg;
    logic [15:0] err;
    int          flush;  // cumulative flush pulses since table start
    int          fwd;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [7:0]      fdata [NF];
  logic [NF-1:0]   fvalid = '0;
  logic [NF*8-1:0] feed_data;
  logic [NF-1:0]   ready;
  logic [7:0]      pdata;
  logic            pvalid, pstart, pflush;
  logic            pdone = 1'b0;
  logic [NF-1:0]   grant;
  logic [15:0]     msg_cnt, err_cnt;

  int checks = 0;
  int errors = 0;

  always_comb begin
    for (int i = 0; i < NF; i++) feed_data[i*8 +: 8] = fdata[i];
  end

  parser_feed_arbiter #(
    .NUM_FEEDS      (NF),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_in           (clk),
    .reset_n_in       (rst_n),
    .feed_data_in     (feed_data),
    .feed_valid_in    (fvalid),
    .feed_ready_out   (ready),
    .parser_data_out  (pdata),
    .parser_valid_out (pvalid),
    .parser_start_out (pstart),
    .parser_flush_out (pflush),
    .parser_done_in   (pdone),
    .grant_out        (grant),
    .msg_count_out    (msg_cnt),
    .err_count_out    (err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Capture forwarded bytes, flush pulses and each new grant.
  logic [8:0] fwd_q[$];
  logic [3:0] gnt_log[$];
  logic [3:0] prev_gnt = '0;
  int flush_cnt = 0;
  int flush_cyc = 0;
  always @(negedge clk) begin
    if (pvalid) fwd_q.push_back({pstart, pdata});
    if (pflush) begin
      flush_cnt = flush_cnt + 1;
      flush_cyc = cyc;
    end
    if (grant != prev_gnt && grant != '0) gnt_log.push_back(grant);
    prev_gnt = grant;
  end

  // Parser model: raise done in the done_dly-th cycle of WAIT_DONE.
  logic done_en = 1'b0;
  int   done_dly = 1;
  int   wd_cnt = 0;
  always @(negedge clk) begin
    if (grant != '0 && ready == '0) wd_cnt = wd_cnt + 1;
    else wd_cnt = 0;
    pdone = done_en && (grant != '0) && (ready == '0) && (wd_cnt == done_dly);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic note_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic logic [7:0] body(input fidx_t f, input int k);
    return 8'h82 + 8'(k) + {2'b00, f, 4'h0};
  endfunction

  task automatic apply_reset();
    rst_n   = 1'b0;
    fvalid  = '0;
    done_en = 1'b0;
    for (int i = 0; i < NF; i++) fdata[i] = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Present a byte and hold it until it is accepted; returns the grant seen.
  task automatic push_byte(input fidx_t f, input logic [7:0] b, output logic [3:0] g_seen);
    bit ok = 1'b0;
    fdata[f]  = b;
    fvalid[f] = 1'b1;
    g_seen    = '0;
    for (int i = 0; i < 60; i++) begin
      if (ready[f]) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) note_timeout("push_byte");
    else begin
      g_seen = grant;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_msg(input fidx_t f, input logic [7:0] len, output logic [3:0] g_first);
    logic [3:0] g;
    push_byte(f, len, g_first);
    for (int k = 0; k < int'(len); k++) push_byte(f, body(f, k), g);
    fvalid[f] = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (grant == '0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) note_timeout(name);
  endtask

  task automatic wait_grant(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (grant != '0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) note_timeout(name);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t       tbl [7];
    logic [3:0] g;
    logic [8:0] exp_b;
    logic [8:0] exp2 [8];
    logic [3:0] exp_g [4];
    int base, fl_base, gl_base, mism, hs_cyc;

    tbl[0] = '{2'd0, 8'd5, 3, 4'b0001, 16'd1, 16'd0, 0, 6};
    tbl[1] = '{2'd1, 8'd0, 1, 4'b0010, 16'd1, 16'd1, 0, 0};
    tbl[2] = '{2'd2, 8'd1, 1, 4'b0100, 16'd2, 16'd1, 0, 2};
    tbl[3] = '{2'd3, 8'd3, 8, 4'b1000, 16'd3, 16'd1, 0, 4};  // done on the timeout cycle
    tbl[4] = '{2'd2, 8'd1, 0, 4'b0100, 16'd3, 16'd2, 1, 2};  // WAIT_DONE timeout
    tbl[5] = '{2'd0, 8'd0, 1, 4'b0001, 16'd3, 16'd3, 1, 0};
    tbl[6] = '{2'd3, 8'd2, 2, 4'b1000, 16'd4, 16'd3, 1, 3};

    apply_reset();
    check("reset_grant", 32'(grant), 0);
    check("reset_ready", 32'(ready), 0);
    check("reset_pvalid", 32'(pvalid), 0);
    check("reset_msg", 32'(msg_cnt), 0);
    check("reset_err", 32'(err_cnt), 0);

    // Table of single-feed messages.
    fl_base = flush_cnt;
    for (int r = 0; r < 7; r++) begin
      base     = fwd_q.size();
      done_dly = tbl[r].dly;
      done_en  = 1'b1;
      run_msg(tbl[r].feed, tbl[r].len, g);
      wait_idle("tbl_idle");
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_grant", r), 32'(g), 32'(tbl[r].gnt));
      check($sformatf("tbl%0d_msg", r), 32'(msg_cnt), 32'(tbl[r].msg));
      check($sformatf("tbl%0d_err", r), 32'(err_cnt), 32'(tbl[r].err));
      check($sformatf("tbl%0d_flush", r), 32'(flush_cnt - fl_base), 32'(tbl[r].flush));
      check($sformatf("tbl%0d_fwd_n", r), 32'(fwd_q.size() - base), 32'(tbl[r].fwd));
      mism = 0;
      for (int k = 0; k < fwd_q.size() - base; k++) begin
        exp_b = (k == 0) ? {1'b1, tbl[r].len} : {1'b0, body(tbl[r].feed, k - 1)};
        if (fwd_q[base + k] !== exp_b) mism++;
      end
      check($sformatf("tbl%0d_fwd_bytes", r), 32'(mism), 0);
    end
    check("tbl_grant_released", 32'(grant), 0);

    // Feeds 0 and 2 contend with 2-byte messages: grants alternate, no interleave.
    apply_reset();
    done_en  = 1'b1;
    done_dly = 1;
    base     = fwd_q.size();
    gl_base  = gnt_log.size();
    fork
      begin
        logic [3:0] ga;
        run_msg(2'd0, 8'd1, ga);
        run_msg(2'd0, 8'd1, ga);
      end
      begin
        logic [3:0] gb;
        run_msg(2'd2, 8'd1, gb);
        run_msg(2'd2, 8'd1, gb);
      end
    join
    wait_idle("rr_idle");
    @(posedge clk);
    #1;
    exp_g = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
    exp2  = '{9'h101, 9'h082, 9'h101, 9'h0A2, 9'h101, 9'h082, 9'h101, 9'h0A2};
    check("rr_grant_n", 32'(gnt_log.size() - gl_base), 4);
    mism = 0;
    for (int k = 0; k < 4; k++) begin
      if (gl_base + k >= gnt_log.size() || gnt_log[gl_base + k] !== exp_g[k]) mism++;
    end
    check("rr_grant_order", 32'(mism), 0);
    check("rr_fwd_n", 32'(fwd_q.size() - base), 8);
    mism = 0;
    for (int k = 0; k < 8; k++) begin
      if (base + k >= fwd_q.size() || fwd_q[base + k] !== exp2[k]) mism++;
    end
    check("rr_fwd_bytes", 32'(mism), 0);
    check("rr_msg", 32'(msg_cnt), 4);

    // Zero length from feed 1, then feeds 0 and 2 both request: feed 2 wins.
    apply_reset();
    base = fwd_q.size();
    push_byte(2'd1, 8'h00, g);
    fvalid[1] = 1'b0;
    check("zl_grant", 32'(g), 32'(4'b0010));
    fdata[0]  = 8'h00;
    fdata[2]  = 8'h00;
    fvalid[0] = 1'b1;
    fvalid[2] = 1'b1;
    wait_grant("zl_next");
    check("zl_next_grant", 32'(grant), 32'(4'b0100));
    @(posedge clk);
    #1;
    fvalid[2] = 1'b0;
    wait_grant("zl_third");
    check("zl_third_grant", 32'(grant), 32'(4'b0001));
    @(posedge clk);
    #1;
    fvalid[0] = 1'b0;
    @(posedge clk);
    #1;
    check("zl_err", 32'(err_cnt), 3);
    check("zl_fwd_n", 32'(fwd_q.size() - base), 0);

    // Feed 3 stalls after two body bytes of a 4-byte body: flush 9 cycles later.
    apply_reset();
    base    = fwd_q.size();
    fl_base = flush_cnt;
    push_byte(2'd3, 8'd4, g);
    push_byte(2'd3, body(2'd3, 0), g);
    push_byte(2'd3, body(2'd3, 1), g);
    fvalid[3] = 1'b0;
    hs_cyc    = cyc - 1;
    for (int i = 0; i < 20; i++) begin
      if (flush_cnt != fl_base) break;
      @(posedge clk);
      #1;
    end
    repeat (3) @(posedge clk);
    #1;
    check("to_flush_n", 32'(flush_cnt - fl_base), 1);
    check("to_flush_cycle", 32'(flush_cyc - hs_cyc), 9);
    check("to_err", 32'(err_cnt), 1);
    check("to_msg", 32'(msg_cnt), 0);
    check("to_grant", 32'(grant), 0);
    check("to_fwd_n", 32'(fwd_q.size() - base), 3);

    // Asynchronous reset in the middle of a BODY transfer.
    apply_reset();
    done_en  = 1'b1;
    done_dly = 1;
    run_msg(2'd1, 8'd1, g);
    wait_idle("rst_pre_idle");
    push_byte(2'd2, 8'd4, g);
    push_byte(2'd2, body(2'd2, 0), g);
    fl_base = flush_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_grant", 32'(grant), 0);
    check("rst_ready", 32'(ready), 0);
    check("rst_pvalid", 32'(pvalid), 0);
    check("rst_pstart", 32'(pstart), 0);
    check("rst_pdata", 32'(pdata), 0);
    check("rst_msg", 32'(msg_cnt), 0);
    #10;
    rst_n     = 1'b1;
    fdata[0]  = 8'h01;
    fvalid[0] = 1'b1;
    @(posedge clk);
    #1;
    wait_grant("rst_first");
    check("rst_first_grant", 32'(grant), 32'(4'b0001));
    check("rst_no_flush", 32'(flush_cnt - fl_base), 0);
    fvalid = '0;
    apply_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
